// File: rtl/cbx_param_ccff.sv
// Parametrised X-channel connection block with a double-buffered serial configuration chain.
// A shift register is loaded while the fabric keeps running; an explicit commit copies it into the active register.
module cbx_param_ccff #(
    parameter int W       = 4,
    parameter int P       = 10,
    parameter int SELW    = $clog2(2 * W + 1),
    parameter int REG_OUT = 0
) (
    input  logic         prog_clk,
    input  logic         prog_reset_n,
    input  logic         ccff_en,
    input  logic         ccff_head,
    output logic         ccff_tail,
    input  logic         cfg_commit,
    output logic         cfg_full,
    output logic         cfg_valid,
    output logic         cfg_err,
    input  logic [W-1:0] chanx_left_in,
    input  logic [W-1:0] chanx_right_in,
    output logic [W-1:0] chanx_left_out,
    output logic [W-1:0] chanx_right_out,
    output logic [P-1:0] ipin_out
);

    localparam int N  = P * SELW;
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  sr_q, sr_d;
    logic [N-1:0]  act_q, act_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          full;
    logic [P-1:0]  ipin_comb;

    assign chanx_right_out = chanx_left_in;
    assign chanx_left_out  = chanx_right_in;

    assign full      = (cnt_q == CW'(N));
    assign cfg_full  = full;
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;
    assign ccff_tail = sr_q[N-1];

    // Commit samples the pre-shift contents, so a same-cycle shift starts the next load at count 1.
    always_comb begin
        sr_d    = sr_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (ccff_en) begin
            sr_d = {sr_q[N-2:0], ccff_head};
            if (!full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (cfg_commit) begin
            if (full) begin
                act_d   = sr_q;
                valid_d = 1'b1;
                cnt_d   = ccff_en ? CW'(1) : '0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            sr_q    <= '0;
            act_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < P; gi++) begin : g_ipin
            logic [SELW-1:0] sel;
            logic            pin_bit;

            // Lowest-indexed bit of each field is the select MSB.
            for (gj = 0; gj < SELW; gj++) begin : g_sel
                assign sel[SELW-1-gj] = act_q[gi*SELW+gj];
            end

            always_comb begin
                pin_bit = 1'b0;
                for (int t = 0; t < W; t++) begin
                    if (sel == SELW'(t + 1)) begin
                        pin_bit = chanx_left_in[t];
                    end
                    if (sel == SELW'(W + 1 + t)) begin
                        pin_bit = chanx_right_in[t];
                    end
                end
                if (!valid_q) begin
                    pin_bit = 1'b0;
                end
            end

            assign ipin_comb[gi] = pin_bit;
        end

        if (REG_OUT != 0) begin : g_reg_out
            logic [P-1:0] ipin_q, ipin_d;

            assign ipin_d = ipin_comb;

            always_ff @(posedge prog_clk) begin
                if (!prog_reset_n) begin
                    ipin_q <= '0;
                end else begin
                    ipin_q <= ipin_d;
                end
            end

            assign ipin_out = ipin_q;
        end else begin : g_comb_out
            assign ipin_out = ipin_comb;
        end
    endgenerate

endmodule

// File: tb/tb_cbx_param_ccff.sv
// Self-checking bench for cbx_param_ccff: directed and random bitstreams against a bit-history reference model.
// Two instances cover combinational and registered ipin outputs.
module tb_cbx_param_ccff;

    localparam int W    = 4;
    localparam int P    = 10;
    localparam int SELW = 4;
    localparam int N    = P * SELW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         head = 1'b0;
    logic         commit = 1'b0;
    logic [W-1:0] left_in = '0;
    logic [W-1:0] right_in = '0;

    logic         tail0, full0, valid0, err0;
    logic [W-1:0] lo0, ro0;
    logic [P-1:0] ipin0;
    logic         tail1, full1, valid1, err1;
    logic [W-1:0] lo1, ro1;
    logic [P-1:0] ipin1;

    cbx_param_ccff #(.W(W), .P(P), .SELW(SELW), .REG_OUT(0)) dut_comb (
        .prog_clk(clk), .prog_reset_n(rst_n), .ccff_en(en), .ccff_head(head),
        .ccff_tail(tail0), .cfg_commit(commit), .cfg_full(full0), .cfg_valid(valid0),
        .cfg_err(err0), .chanx_left_in(left_in), .chanx_right_in(right_in),
        .chanx_left_out(lo0), .chanx_right_out(ro0), .ipin_out(ipin0)
    );

    cbx_param_ccff #(.W(W), .P(P), .SELW(SELW), .REG_OUT(1)) dut_reg (
        .prog_clk(clk), .prog_reset_n(rst_n), .ccff_en(en), .ccff_head(head),
        .ccff_tail(tail1), .cfg_commit(commit), .cfg_full(full1), .cfg_valid(valid1),
        .cfg_err(err1), .chanx_left_in(left_in), .chanx_right_in(right_in),
        .chanx_left_out(lo1), .chanx_right_out(ro1), .ipin_out(ipin1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the last N bits shifted (hist[N-1] newest), bits since commit, decoded selects.
    bit           hist[$];
    int           cnt_m;
    int           act_m[P];
    bit           valid_m;
    bit           err_m;
    logic [P-1:0] exp_reg;
    bit           rand_ch = 1'b1;

    function automatic int sel_from_sr(int p);
        int s = 0;
        for (int j = 0; j < SELW; j++) begin
            s = s * 2 + int'(hist[N-1-(p*SELW+j)]);
        end
        return s;
    endfunction

    function automatic logic [P-1:0] model_ipin();
        logic [P-1:0] r = '0;
        for (int p = 0; p < P; p++) begin
            int s = act_m[p];
            if (!valid_m) r[p] = 1'b0;
            else if (s >= 1 && s <= W) r[p] = left_in[s-1];
            else if (s >= W + 1 && s <= 2 * W) r[p] = right_in[s-1-W];
            else r[p] = 1'b0;
        end
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < N; i++) hist.push_back(1'b0);
        cnt_m   = 0;
        valid_m = 1'b0;
        err_m   = 1'b0;
        for (int p = 0; p < P; p++) act_m[p] = 0;
    endtask

    task automatic model_edge(input bit e, input bit h, input bit c, input bit rn);
        if (!rn) begin
            model_reset();
        end else begin
            if (c) begin
                if (cnt_m == N) begin
                    for (int p = 0; p < P; p++) act_m[p] = sel_from_sr(p);
                    valid_m = 1'b1;
                    cnt_m   = 0;
                end else begin
                    err_m = 1'b1;
                end
            end
            if (e) begin
                hist.push_back(h);
                void'(hist.pop_front());
                if (cnt_m < N) cnt_m++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("tail",      32'(tail0),  32'(hist[0]));
        chk("full",      32'(full0),  32'(cnt_m == N));
        chk("valid",     32'(valid0), 32'(valid_m));
        chk("err",       32'(err0),   32'(err_m));
        chk("ipin_comb", 32'(ipin0),  32'(model_ipin()));
        chk("right_out", 32'(ro0),    32'(left_in));
        chk("left_out",  32'(lo0),    32'(right_in));
        chk("r_tail",    32'(tail1),  32'(hist[0]));
        chk("r_valid",   32'(valid1), 32'(valid_m));
        chk("ipin_reg",  32'(ipin1),  32'(exp_reg));
    endtask

    task automatic step(input bit e, input bit h, input bit c, input bit rn);
        logic [P-1:0] nxt;
        @(negedge clk);
        en     = e;
        head   = h;
        commit = c;
        rst_n  = rn;
        if (rand_ch) begin
            left_in  = W'($urandom);
            right_in = W'($urandom);
        end
        nxt = rn ? model_ipin() : '0;
        @(posedge clk);
        model_edge(e, h, c, rn);
        exp_reg = nxt;
        #1;
        check_all();
    endtask

    // Stream order: ipin P-1 first, each field LSB first, so ipin 0's MSB is the last bit.
    task automatic load(input int sels[P], input bit do_commit);
        for (int p = P - 1; p >= 0; p--) begin
            for (int b = 0; b < SELW; b++) begin
                step(1'b1, bit'((sels[p] >> b) & 1), 1'b0, 1'b1);
            end
        end
        if (do_commit) step(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    int  sels[P];
    bit  bits[$];

    initial begin
        model_reset();
        exp_reg = '0;

        // Reset and pass-through
        rand_ch  = 1'b0;
        left_in  = 4'hA;
        right_in = 4'h5;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_ipin",  32'(ipin0), 32'h0);
        chk("rst_tail",  32'(tail0), 32'h0);
        chk("rst_full",  32'(full0), 32'h0);
        chk("rst_valid", 32'(valid0), 32'h0);
        chk("rst_err",   32'(err0), 32'h0);
        chk("pass_A",    32'(ro0), 32'hA);

        // Load ipin0=1, ipin1=8 and commit
        for (int p = 0; p < P; p++) sels[p] = 0;
        sels[0] = 1;
        sels[1] = 8;
        left_in  = 4'b0001;
        right_in = 4'b1000;
        load(sels, 1'b0);
        chk("full_before_commit", 32'(full0), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("valid_after_commit", 32'(valid0), 32'h1);
        chk("ipin_route", 32'(ipin0), 32'h003);
        chk("ipin_reg_lag", 32'(ipin1), 32'h000);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ipin_reg_route", 32'(ipin1), 32'h003);
        rand_ch = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Early commit after 39 bits
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 39; i++) step(1'b1, bit'($urandom), 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("early_err",   32'(err0), 32'h1);
        chk("early_valid", 32'(valid0), 32'h0);
        chk("early_ipin",  32'(ipin0), 32'h0);
        step(1'b1, bit'($urandom), 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("late_valid", 32'(valid0), 32'h1);
        chk("err_sticky", 32'(err0), 32'h1);

        // Daisy chain: 80 bits from reset
        step(1'b0, 1'b0, 1'b0, 1'b0);
        bits.delete();
        for (int i = 1; i <= 2 * N; i++) begin
            bit b = bit'($urandom);
            bits.push_back(b);
            step(1'b1, b, 1'b0, 1'b1);
            if (i > N) chk("daisy_tail", 32'(tail0), 32'(bits[i-N-1]));
            if (i >= N) chk("daisy_full", 32'(full0), 32'h1);
        end

        // Commit with simultaneous shift: count restarts at 1
        step(1'b1, bit'($urandom), 1'b1, 1'b1);
        chk("simul_full", 32'(full0), 32'h0);
        for (int i = 0; i < N - 2; i++) step(1'b1, bit'($urandom), 1'b0, 1'b1);
        chk("simul_not_full", 32'(full0), 32'h0);
        step(1'b1, bit'($urandom), 1'b0, 1'b1);
        chk("simul_full_again", 32'(full0), 32'h1);

        // Random bitstreams, selects over the full 0..15 range
        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < P; p++) sels[p] = int'($urandom_range(0, 15));
            load(sels, 1'b1);
            for (int i = 0; i < 4; i++)
                step(bit'($urandom_range(0, 3) == 0), bit'($urandom), bit'($urandom_range(0, 7) == 0), 1'b1);
        end

        // Reset in the middle of a reload
        rand_ch  = 1'b0;
        left_in  = 4'hF;
        right_in = 4'hF;
        for (int p = 0; p < P; p++) sels[p] = (p % 8) + 1;
        load(sels, 1'b1);
        chk("reload_on", 32'(ipin0), 32'h3FF);
        for (int i = 0; i < 20; i++) step(1'b1, bit'($urandom), 1'b0, 1'b1);
        chk("reload_keeps", 32'(ipin0), 32'h3FF);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_valid", 32'(valid0), 32'h0);
        chk("mid_rst_ipin",  32'(ipin0), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < N - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("partial_ipin", 32'(ipin0), 32'h0);
        load(sels, 1'b1);
        chk("reloaded_ipin", 32'(ipin0), 32'h3FF);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
